// File: rtl/div_16x8_seq.sv
// ---------------------------------------------------------------------------
// div_16x8_seq
//   Sequential restoring divider: 16-bit dividend R by 8-bit divisor B.
//   It produces an 8-bit quotient Q and an 8-bit remainder REM, resolving one
//   quotient bit per cycle. It is the inverse of the 8x8 multiplier family:
//   it recovers an operand from a 16-bit product.
//
//   Optional feature macro: DIV_ROUND_EN
//     Defined   : an extra ROUND state rounds Q to nearest (2*REM >= B
//                 rounds up). An 8'hFF quotient that would round up
//                 raises ovf. REM keeps the truncated remainder.
//     Undefined : truncating quotient, no ROUND state.
//
// Ports
//   clk        in   1   clock, rising edge
//   rst        in   1   synchronous active-high reset
//   R          in  16   dividend
//   B          in   8   divisor
//   in_valid   in   1   R/B valid
//   in_ready   out  1   divider idle and able to accept
//   Q          out  8   quotient (8'hFF on overflow)
//   REM        out  8   remainder (8'hFF on overflow)
//   ovf        out  1   quotient does not fit in 8 bits, or B == 0
//   out_valid  out  1   Q/REM/ovf valid
//   out_ready  in   1   downstream accepts result
// ---------------------------------------------------------------------------
module div_16x8_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] R,
  input  logic [7:0]  B,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  Q,
  output logic [7:0]  REM,
  output logic        ovf,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
`ifdef DIV_ROUND_EN
    ROUND = 2'd3,
`endif
    DONE  = 2'd2
  } state_t;

  state_t      state;
  state_t      next_state;

  // Captured operands. Only the low dividend byte is kept: the high byte
  // seeds the partial remainder at accept time.
  logic [7:0]  r_lo;
  logic [7:0]  div_b;
  logic [7:0]  p;        // partial remainder; always < div_b, so 8 bits suffice
  logic [2:0]  cnt;      // index of the quotient bit being resolved

  logic        ovf_in;
  logic [8:0]  t;
  logic        ge;
  logic [7:0]  p_step;
  logic [7:0]  p_next;
  logic        in_ready_d;
  logic        out_valid_d;

`ifdef DIV_ROUND_EN
  logic        round_up;
`endif

  // Operand-level overflow: the quotient needs more than 8 bits when
  // R[15:8] >= B. This also catches B == 0.
  assign ovf_in = (R[15:8] >= B);

  // One restoring step. Shift in the next dividend bit, then compare in 9 bits.
  // Because p < div_b, the difference t - div_b is < div_b, so its low 8 bits
  // are exact.
  assign t      = {p, r_lo[cnt]};
  assign ge     = (t >= {1'b0, div_b});
  assign p_step = t[7:0] - div_b;
  assign p_next = ge ? p_step : t[7:0];

`ifdef DIV_ROUND_EN
  // 2*REM >= B, evaluated on the final partial remainder
  assign round_up = ({p, 1'b0} >= {1'b0, div_b});
`endif

  // State register plus registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= next_state;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (ovf_in) begin
            next_state = DONE;
          end else begin
            next_state = CALC;
          end
        end else begin
          next_state = IDLE;
        end
      end
      CALC: begin
        if (cnt == 3'd0) begin
`ifdef DIV_ROUND_EN
          next_state = ROUND;
`else
          next_state = DONE;
`endif
        end else begin
          next_state = CALC;
        end
      end
`ifdef DIV_ROUND_EN
      ROUND: begin
        next_state = DONE;
      end
`endif
      DONE: begin
        if (out_ready) begin
          next_state = IDLE;
        end else begin
          next_state = DONE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Output decode. Handshake flags follow the state being entered, so the
  // registered flags line up with the state register.
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    case (next_state)
      IDLE: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
      DONE: begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b1;
      end
      default: begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Datapath. Operand capture, the restoring iteration and the result
  // registers. Results are touched only on the transition into DONE, or in
  // CALC/ROUND.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lo  <= 8'h00;
      div_b <= 8'h00;
      p     <= 8'h00;
      cnt   <= 3'd0;
      Q     <= 8'h00;
      REM   <= 8'h00;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            r_lo  <= R[7:0];
            div_b <= B;
            p     <= R[15:8];
            cnt   <= 3'd7;
            if (ovf_in) begin
              Q   <= 8'hFF;
              REM <= 8'hFF;
              ovf <= 1'b1;
            end
          end
        end
        CALC: begin
          p      <= p_next;
          Q[cnt] <= ge;
          cnt    <= cnt - 3'd1;
          if (cnt == 3'd0) begin
            REM <= p_next;
            ovf <= 1'b0;
          end
        end
`ifdef DIV_ROUND_EN
        ROUND: begin
          if (round_up) begin
            if (Q == 8'hFF) begin
              ovf <= 1'b1;
            end else begin
              Q <= Q + 8'd1;
            end
          end
        end
`endif
        DONE: begin
          // results held until the output handshake
        end
        default: begin
          // unreachable encodings hold everything; next_state recovers to IDLE
        end
      endcase
    end
  end

endmodule
